sram_responder: RTL and testbench

//  Synthesizable, cycle-accurate SRAM device model answering the CPU memory-stage SRAM initiator.

---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_responder_if.sv | 34 +++
 rtl/sram_resp_array.sv | 43 ++++
 rtl/sram_responder.sv | 146 ++++++++++++++
 tb/tb_sram_responder.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared widths, byte-lane layout and responder FSM states.
// Imported by the SRAM responder interface, storage array and top.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    // Byte lanes: LB = DQ[7:0], UB = DQ[15:8]
    localparam int LANE_W  = 8;
    localparam int LB_LANE = 0;
    localparam int UB_LANE = 1;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE
    } sram_state_t;

    // Saturating event counter step
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if: SRAM address/control pins driven by the initiator.
// DQ is bidirectional and stays a plain inout port on the responder.
interface sram_responder_if
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W
);

    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_UB_N;
    logic              SRAM_LB_N;
    logic              SRAM_WE_N;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;

    modport master (
        output SRAM_ADDR,
        output SRAM_UB_N,
        output SRAM_LB_N,
        output SRAM_WE_N,
        output SRAM_CE_N,
        output SRAM_OE_N
    );

    modport slave (
        input SRAM_ADDR,
        input SRAM_UB_N,
        input SRAM_LB_N,
        input SRAM_WE_N,
        input SRAM_CE_N,
        input SRAM_OE_N
    );

endinterface

// File: rtl/sram_resp_array.sv
// sram_resp_array: DEPTH x DATA_W storage, byte-lane synchronous write,
// asynchronous read. Addresses wrap modulo DEPTH; contents are not reset.
module sram_resp_array
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int DEPTH  = 2**18
) (
    input  logic              clk,
    input  logic              we,
    input  logic [1:0]        be,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IW-1:0]     widx;
    logic [IW-1:0]     ridx;

    function automatic logic [IW-1:0] wrap(input logic [ADDR_W-1:0] a);
        return IW'(32'(a) % DEPTH);
    endfunction

    assign widx  = wrap(waddr);
    assign ridx  = wrap(raddr);
    assign rdata = mem[ridx];

    // Commit only the byte lanes whose enable is asserted
    always_ff @(posedge clk) begin
        if (we) begin
            if (be[LB_LANE])
                mem[widx][LANE_W-1:0] <= wdata[LANE_W-1:0];
            if (be[UB_LANE])
                mem[widx][DATA_W-1:LANE_W] <= wdata[DATA_W-1:LANE_W];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// sram_responder: cycle-accurate SRAM device model with fixed read latency.
// Optional protocol checker enabled by defining SRAM_RESP_PROTOCHECK_EN.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int DEPTH    = 2**18,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_responder_if.slave   bus,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt,
    output logic              proto_err
);

    sram_state_t       state;
    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_be;
    logic [2:0]        lat_cnt;

    logic              wr_en;
    logic              rd_req;
    logic              addr_chg;
    logic [1:0]        cur_be;
    logic [1:0]        drv;
    logic [DATA_W-1:0] rd_data;

    assign cur_be   = ~{bus.SRAM_UB_N, bus.SRAM_LB_N};
    assign wr_en    = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
    assign rd_req   = !bus.SRAM_CE_N && bus.SRAM_WE_N && !bus.SRAM_OE_N;
    assign addr_chg = bus.SRAM_ADDR != lat_addr;

    sram_resp_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .be    (cur_be),
        .waddr (bus.SRAM_ADDR),
        .wdata (SRAM_DQ),
        .raddr (lat_addr),
        .rdata (rd_data)
    );

    // Read FSM: sample, count down the latency, then drive until released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lat_addr <= '0;
            lat_be   <= '0;
            lat_cnt  <= '0;
            rd_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rd_req) begin
                        state    <= RD_WAIT;
                        lat_addr <= bus.SRAM_ADDR;
                        lat_be   <= cur_be;
                        lat_cnt  <= 3'(READ_LAT - 1);
                    end
                end
                RD_WAIT: begin
                    if (!rd_req) begin
                        state <= IDLE;
                    end else if (addr_chg) begin
                        lat_addr <= bus.SRAM_ADDR;
                        lat_be   <= cur_be;
                        lat_cnt  <= 3'(READ_LAT - 1);
                    end else if (lat_cnt == 3'd0) begin
                        state  <= RD_DRIVE;
                        rd_cnt <= sat_inc(rd_cnt);
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RD_DRIVE: begin
                    if (!rd_req) begin
                        state <= IDLE;
                    end else if (addr_chg) begin
                        state    <= RD_WAIT;
                        lat_addr <= bus.SRAM_ADDR;
                        lat_be   <= cur_be;
                        lat_cnt  <= 3'(READ_LAT - 1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Count committed writes, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wr_cnt <= '0;
        else if (wr_en)
            wr_cnt <= sat_inc(wr_cnt);
    end

    // Lane drivers follow registered state so reset releases DQ at once
    assign drv = {2{state == RD_DRIVE}} & lat_be;

    assign SRAM_DQ[LANE_W-1:0] =
        drv[LB_LANE] ? rd_data[LANE_W-1:0] : 'z;
    assign SRAM_DQ[DATA_W-1:LANE_W] =
        drv[UB_LANE] ? rd_data[DATA_W-1:LANE_W] : 'z;

`ifdef SRAM_RESP_PROTOCHECK_EN
    logic viol_addr;
    logic viol_cont;
    logic viol_lane;

    assign viol_addr = (state == RD_WAIT) && !bus.SRAM_CE_N && addr_chg;
    assign viol_cont = (state == RD_DRIVE) && !bus.SRAM_WE_N;
    assign viol_lane = !bus.SRAM_CE_N && (cur_be == 2'b00)
                     && (!bus.SRAM_WE_N || !bus.SRAM_OE_N);

    // Sticky protocol-error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            proto_err <= 1'b0;
        else if (viol_addr || viol_cont || viol_lane)
            proto_err <= 1'b1;
    end

`ifndef SYNTHESIS
    // Report each violation as it is sampled
    always @(posedge clk) begin
        if (!rst) begin
            if (viol_addr) $error("sram_responder: address change in RD_WAIT");
            if (viol_cont) $error("sram_responder: WE_N low while driving DQ");
            if (viol_lane) $error("sram_responder: access with no byte lane");
        end
    end
`endif
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: randomized + directed scoreboard bench for sram_responder.
// Expected pin values come from a cycle-count reference model of the SRAM.
module tb_sram_responder;
    import sram_pkg::*;

    localparam int AW    = 18;
    localparam int DW    = 16;
    localparam int DEPTH = 65536;
    localparam int LAT   = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    tri1 [DW-1:0]   dq;
    logic [DW-1:0]  tb_dq = '0;
    logic           tb_drv = 1'b0;
    logic [15:0]    rd_cnt;
    logic [15:0]    wr_cnt;
    logic           proto_err;

    assign dq = tb_drv ? tb_dq : 'z;

    sram_responder_if #(.ADDR_W(AW)) bus ();

    sram_responder #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .READ_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .SRAM_DQ   (dq),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] dq;
        logic [15:0] rdc;
        logic [15:0] wrc;
        logic        perr;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: storage map plus one outstanding read with a due time
    logic [15:0] mem_m [int];
    bit          m_act  = 0;
    bit          m_drv  = 0;
    logic [17:0] m_addr = '0;
    logic [1:0]  m_be   = '0;
    int          m_due  = 0;
    int          m_cyc  = 0;
    int          m_rdc  = 0;
    int          m_wrc  = 0;
    bit          m_perr = 0;

    task automatic chk(input string nm, input int c,
                       input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, exp);
        end
    endtask

    function automatic logic [15:0] rd_word(input logic [17:0] a);
        int w;
        w = int'(a) % DEPTH;
        return mem_m.exists(w) ? mem_m[w] : 16'h0000;
    endfunction

    task automatic step(input logic [17:0] a, input logic ub, input logic lb,
                        input logic we, input logic ce, input logic oe,
                        input logic [15:0] d, input bit r, input bit drive);
        exp_t        e;
        logic [15:0] v;
        int          w;
        m_cyc++;
        if (r) begin
            m_act  = 0;
            m_drv  = 0;
            m_rdc  = 0;
            m_wrc  = 0;
            m_perr = 0;
        end else begin
`ifdef SRAM_RESP_PROTOCHECK_EN
            if (m_act && !m_drv && !ce && a != m_addr) m_perr = 1;
            if (m_drv && !we) m_perr = 1;
            if (!ce && ub && lb && (!we || !oe)) m_perr = 1;
`endif
            if (!ce && !we) begin
                w = int'(a) % DEPTH;
                v = rd_word(a);
                if (!lb) v[7:0]  = d[7:0];
                if (!ub) v[15:8] = d[15:8];
                mem_m[w] = v;
                if (m_wrc < 65535) m_wrc++;
            end
            if (!ce && we && !oe) begin
                if (!m_act || a != m_addr) begin
                    m_act  = 1;
                    m_drv  = 0;
                    m_addr = a;
                    m_be   = ~{ub, lb};
                    m_due  = m_cyc + LAT;
                end else if (!m_drv && m_cyc >= m_due) begin
                    m_drv = 1;
                    if (m_rdc < 65535) m_rdc++;
                end
            end else begin
                m_act = 0;
                m_drv = 0;
            end
        end
        e.cyc = m_cyc;
        e.dq  = 16'hFFFF;
        if (drive) begin
            e.dq = d;
        end else if (m_drv) begin
            v = rd_word(m_addr);
            if (m_be[0]) e.dq[7:0]  = v[7:0];
            if (m_be[1]) e.dq[15:8] = v[15:8];
        end
        e.rdc  = 16'(m_rdc);
        e.wrc  = 16'(m_wrc);
        e.perr = m_perr;
        q.push_back(e);
    endtask

    // One bus cycle: pins change on the falling edge, model predicts the rise
    task automatic cyc(input logic [17:0] a, input logic ub, input logic lb,
                       input logic we, input logic ce, input logic oe,
                       input logic [15:0] d, input bit r);
        bit drive;
        @(negedge clk);
        drive         = !we && !r;
        rst           = r;
        bus.SRAM_ADDR = a;
        bus.SRAM_UB_N = ub;
        bus.SRAM_LB_N = lb;
        bus.SRAM_WE_N = we;
        bus.SRAM_CE_N = ce;
        bus.SRAM_OE_N = oe;
        tb_drv        = drive;
        tb_dq         = d;
        if (r) begin
            #1;
            chk("rst_dq", m_cyc, dq, 16'hFFFF);
            chk("rst_rd_cnt", m_cyc, rd_cnt, 16'h0);
            chk("rst_wr_cnt", m_cyc, wr_cnt, 16'h0);
            chk("rst_perr", m_cyc, {15'h0, proto_err}, 16'h0);
        end
        step(a, ub, lb, we, ce, oe, drive ? d : 16'hFFFF, r, drive);
    endtask

    task automatic idle();
        cyc('0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b0);
    endtask

    task automatic rd(input logic [17:0] a, input logic ub, input logic lb);
        cyc(a, ub, lb, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic wr(input logic [17:0] a, input logic ub, input logic lb,
                      input logic [15:0] d);
        cyc(a, ub, lb, 1'b0, 1'b0, 1'b1, d, 1'b0);
    endtask

    // Monitor: compare the pins against the oldest prediction after each rise
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                me = q.pop_front();
                chk("dq", me.cyc, dq, me.dq);
                chk("rd_cnt", me.cyc, rd_cnt, me.rdc);
                chk("wr_cnt", me.cyc, wr_cnt, me.wrc);
                chk("proto_err", me.cyc, {15'h0, proto_err}, {15'h0, me.perr});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout cyc=%0d got=running want=finished", m_cyc);
        $fatal(1, "tb_sram_responder timeout");
    end

    initial begin
        logic [17:0] pool [8];
        logic [17:0] ra;
        int          k;

        bus.SRAM_ADDR = '0;
        bus.SRAM_UB_N = 1'b1;
        bus.SRAM_LB_N = 1'b1;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_CE_N = 1'b1;
        bus.SRAM_OE_N = 1'b1;

        cyc('0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b1);
        cyc('0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b1);
        idle();

        // Full write then read with exact latency
        wr(18'h00010, 1'b0, 1'b0, 16'hBEEF);
        idle();
        repeat (LAT + 2) rd(18'h00010, 1'b0, 1'b0);
        idle();

        // Lower-lane write, full read, then upper-lane-only read
        wr(18'h00010, 1'b1, 1'b0, 16'h3412);
        idle();
        repeat (LAT + 2) rd(18'h00010, 1'b0, 1'b0);
        idle();
        repeat (LAT + 2) rd(18'h00010, 1'b0, 1'b1);
        idle();

        // Reset while waiting, then while driving; storage must survive
        rd(18'h00010, 1'b0, 1'b0);
        cyc('0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b1);
        idle();
        wr(18'h00030, 1'b0, 1'b0, 16'h0F0F);
        repeat (LAT + 1) rd(18'h00010, 1'b0, 1'b0);
        cyc('0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b1);
        idle();
        repeat (LAT + 2) rd(18'h00010, 1'b0, 1'b0);
        idle();

        // Write with OE_N also low: write wins
        cyc(18'h00020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5A5A, 1'b0);
        idle();

        // Address change while waiting restarts the latency
        rd(18'h00010, 1'b0, 1'b0);
        repeat (LAT + 2) rd(18'h00020, 1'b0, 1'b0);
        idle();

        // Randomized traffic over a small pool, some entries aliasing
        for (int i = 0; i < 8; i++) begin
            pool[i] = (i < 2) ? 18'($urandom_range(0, 7)) | 18'h30000
                              : 18'($urandom_range(0, 15));
            wr(pool[i], 1'b0, 1'b0, 16'($urandom));
        end
        ra = pool[0];
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 9);
            if (k < 2 || (k < 4 && m_drv)) begin
                cyc(pool[$urandom_range(0, 7)], 1'($urandom), 1'($urandom),
                    1'b1, 1'($urandom), 1'b1, '0, 1'b0);
            end else if (k < 4) begin
                cyc(pool[$urandom_range(0, 7)], 1'($urandom), 1'($urandom),
                    1'b0, 1'b0, 1'($urandom), 16'($urandom), 1'b0);
            end else begin
                if ($urandom_range(0, 3) == 0)
                    ra = pool[$urandom_range(0, 7)];
                rd(ra, 1'($urandom), 1'($urandom));
            end
        end
        idle();

        // Aliased top address and write-counter saturation
        cyc('0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b1);
        idle();
        for (int i = 0; i <= 65536; i++)
            wr(18'h3FFFF, 1'b0, 1'b0, 16'(i) ^ 16'h5A5A);
        idle();
        repeat (LAT + 2) rd(18'h0FFFF, 1'b0, 1'b0);
        idle();

        @(posedge clk);
        #2;
        chk("drain", m_cyc, 16'(q.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
